// File: rtl/result_tx_interface_pkg.sv
// ============================================================================
// Module : result_tx_interface_pkg
// Brief  : Shared types and constants for the result transmit interface:
//          UART byte width, default frame header byte and the FSM state type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package result_tx_interface_pkg;

    // Width of one UART character.
    localparam int NB_BYTE = 8;

    // Frame header byte used when the header option is built in.
    localparam logic [NB_BYTE-1:0] HEADER_DEFAULT = 8'hA5;

    // Transmit sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/result_tx_interface_if.sv
// ============================================================================
// Module : result_tx_interface_if
// Brief  : Bundle between the ALU / uart_tx side and result_tx_interface.
//          slave  modport : the result_tx_interface block itself
//          master modport : the environment (ALU + uart_tx)
// Signals:
//   i_result  [NB_DATA]  ALU result to transmit
//   i_valid              1-cycle strobe qualifying i_result
//   i_tx_done            1-cycle pulse from uart_tx, byte shifted out
//   o_tx_data [NB_BYTE]  byte presented to uart_tx
//   o_tx_start           1-cycle pulse, uart_tx loads o_tx_data
//   o_busy               high whenever a frame is in progress
//   o_overrun            sticky, a result was dropped while busy
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface result_tx_interface_if #(
    parameter int NB_DATA = 8
);
    import result_tx_interface_pkg::*;

    logic [NB_DATA-1:0] i_result;
    logic               i_valid;
    logic               i_tx_done;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_overrun;

    modport slave (
        input  i_result,
        input  i_valid,
        input  i_tx_done,
        output o_tx_data,
        output o_tx_start,
        output o_busy,
        output o_overrun
    );

    modport master (
        output i_result,
        output i_valid,
        output i_tx_done,
        input  o_tx_data,
        input  o_tx_start,
        input  o_busy,
        input  o_overrun
    );

endinterface

`default_nettype wire

// File: rtl/result_tx_interface.sv
// ============================================================================
// Module : result_tx_interface
// Brief  : Captures an ALU result on i_valid, splits it into bytes (LSB first)
//          and hands them one at a time to uart_tx with a start/done handshake.
//          Build option TX_HEADER_EN: prefix every frame with the HEADER byte.
// Ports  :
//   i_clock  system clock, rising edge
//   i_reset  asynchronous reset, active low
//   bus      result_tx_interface_if.slave (result/valid/done in,
//            tx_data/tx_start/busy/overrun out)
// Params :
//   NB_DATA  result width, multiple of 8 (must match the bus instance)
//   HEADER   frame header byte (only used with TX_HEADER_EN)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_tx_interface
    import result_tx_interface_pkg::*;
#(
    parameter int                 NB_DATA = 8,
    parameter logic [NB_BYTE-1:0] HEADER  = HEADER_DEFAULT
) (
    input  wire logic              i_clock,
    input  wire logic              i_reset,
    result_tx_interface_if.slave   bus
);

    localparam int NBYTES = NB_DATA / NB_BYTE;
`ifdef TX_HEADER_EN
    localparam int NFRAME = NBYTES + 1;
`else
    localparam int NFRAME = NBYTES;
`endif
    localparam int                NB_FRAME = NFRAME * NB_BYTE;
    localparam int                NB_CNT   = $clog2(NBYTES + 2);
    localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(NFRAME);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    state_t              state_q,   state_d;
    logic [NB_FRAME-1:0] shift_q,   shift_d;
    logic [NB_CNT-1:0]   cnt_q,     cnt_d;
    logic [NB_BYTE-1:0]  tx_data_q, tx_data_d;
    logic                overrun_q, overrun_d;

    logic [NB_FRAME-1:0] frame_in;
    logic [NB_FRAME-1:0] shift_next;

    // Header sits in the low byte so that it leaves first.
`ifdef TX_HEADER_EN
    assign frame_in = {bus.i_result, HEADER};
`else
    assign frame_in = bus.i_result;
`endif

    assign shift_next = shift_q >> NB_BYTE;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        // Any strobe outside IDLE is lost, including one coinciding with the
        // final i_tx_done (the FSM is still in WAIT on that edge).
        overrun_d = overrun_q | (bus.i_valid && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    shift_d   = frame_in;
                    cnt_d     = CNT_LOAD;
                    tx_data_d = frame_in[NB_BYTE-1:0];
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_tx_done) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q > CNT_ONE) begin
                        shift_d   = shift_next;
                        tx_data_d = shift_next[NB_BYTE-1:0];
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = (state_q == ST_START);
    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_result_tx_interface.sv
// ============================================================================
// Module : tb_result_tx_interface
// Brief  : Directed self-checking bench for result_tx_interface. Two instances
//          (8-bit and 16-bit results) share clock and reset. Expected bytes
//          follow the frame rule: optional header, then result bytes LSB first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_tx_interface;

`ifdef TX_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #10 clk = ~clk;

    result_tx_interface_if #(.NB_DATA(8))  b8 ();
    result_tx_interface_if #(.NB_DATA(16)) b16 ();

    result_tx_interface #(.NB_DATA(8)) dut8 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (b8)
    );

    result_tx_interface #(.NB_DATA(16)) dut16 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (b16)
    );

    // Byte k of a frame carrying result r.
    function automatic logic [7:0] exp_byte(input logic [15:0] r, input int k);
        logic [15:0] s;
        if (HDR == 1 && k == 0) return 8'hA5;
        s = r >> (8 * (k - HDR));
        return s[7:0];
    endfunction

    task automatic count_starts(input bit sel16, input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (sel16 ? b16.o_tx_start : b8.o_tx_start) cnt++;
        end
    endtask

    task automatic test_reset();
        #500;
        total++; if ({b8.o_tx_start, b8.o_busy, b8.o_overrun, b8.o_tx_data} !== 11'h0) begin
            $display("FAIL reset8: start,busy,ovr,data got %b%b%b %h expected 000 00",
                     b8.o_tx_start, b8.o_busy, b8.o_overrun, b8.o_tx_data);
        end else passed++;
        total++; if ({b16.o_tx_start, b16.o_busy, b16.o_overrun, b16.o_tx_data} !== 11'h0) begin
            $display("FAIL reset16: start,busy,ovr,data got %b%b%b %h expected 000 00",
                     b16.o_tx_start, b16.o_busy, b16.o_overrun, b16.o_tx_data);
        end else passed++;
        #500;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({b8.o_busy, b16.o_busy} !== 2'b00) begin
            $display("FAIL reset_release_busy: got %b expected 00", {b8.o_busy, b16.o_busy});
        end else passed++;
    endtask

    task automatic test_spurious_done();
        int s8, s16;
        @(negedge clk);
        b8.i_tx_done = 1'b1; b16.i_tx_done = 1'b1;
        @(negedge clk);
        b8.i_tx_done = 1'b0; b16.i_tx_done = 1'b0;
        total++; if ({b8.o_busy, b16.o_busy, b8.o_tx_data} !== 10'h0) begin
            $display("FAIL spurious_state: busy8,busy16,data8 got %b%b %h expected 00 00",
                     b8.o_busy, b16.o_busy, b8.o_tx_data);
        end else passed++;
        count_starts(1'b0, 6, s8);
        count_starts(1'b1, 1, s16);
        total++; if (s8 + s16 !== 0) begin
            $display("FAIL spurious_starts: got %0d expected 0", s8 + s16);
        end else passed++;
    endtask

    task automatic test_single_byte();
        int n, starts;
        n = 1 + HDR;
        @(negedge clk); b8.i_result = 8'hFF; b8.i_valid = 1'b1;
        @(negedge clk); b8.i_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            total++; if ({b8.o_tx_start, b8.o_tx_data} !== {1'b1, exp_byte(16'h00FF, k)}) begin
                $display("FAIL single_start[%0d]: start,data got %b,%h expected 1,%h",
                         k, b8.o_tx_start, b8.o_tx_data, exp_byte(16'h00FF, k));
            end else passed++;
            repeat (3) begin
                @(negedge clk);
                total++; if ({b8.o_tx_start, b8.o_busy, b8.o_tx_data} !== {2'b01, exp_byte(16'h00FF, k)}) begin
                    $display("FAIL single_wait[%0d]: start,busy,data got %b%b,%h expected 01,%h",
                             k, b8.o_tx_start, b8.o_busy, b8.o_tx_data, exp_byte(16'h00FF, k));
                end else passed++;
            end
            b8.i_tx_done = 1'b1;
            @(negedge clk); b8.i_tx_done = 1'b0;
        end
        total++; if ({b8.o_busy, b8.o_tx_start} !== 2'b00) begin
            $display("FAIL single_end: busy,start got %b%b expected 00", b8.o_busy, b8.o_tx_start);
        end else passed++;
        count_starts(1'b0, 6, starts);
        total++; if (starts !== 0) begin
            $display("FAIL single_extra_starts: got %0d expected 0", starts);
        end else passed++;
    endtask

    task automatic test_two_byte();
        int n, starts;
        n = 2 + HDR;
        @(negedge clk); b16.i_result = 16'h1234; b16.i_valid = 1'b1;
        @(negedge clk); b16.i_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            total++; if ({b16.o_tx_start, b16.o_tx_data} !== {1'b1, exp_byte(16'h1234, k)}) begin
                $display("FAIL two_start[%0d]: start,data got %b,%h expected 1,%h",
                         k, b16.o_tx_start, b16.o_tx_data, exp_byte(16'h1234, k));
            end else passed++;
            repeat (2) begin
                @(negedge clk);
                total++; if ({b16.o_tx_start, b16.o_busy, b16.o_tx_data} !== {2'b01, exp_byte(16'h1234, k)}) begin
                    $display("FAIL two_wait[%0d]: start,busy,data got %b%b,%h expected 01,%h",
                             k, b16.o_tx_start, b16.o_busy, b16.o_tx_data, exp_byte(16'h1234, k));
                end else passed++;
            end
            b16.i_tx_done = 1'b1;
            @(negedge clk); b16.i_tx_done = 1'b0;
        end
        total++; if ({b16.o_busy, b16.o_overrun} !== 2'b00) begin
            $display("FAIL two_end: busy,ovr got %b%b expected 00", b16.o_busy, b16.o_overrun);
        end else passed++;
        count_starts(1'b1, 6, starts);
        total++; if (starts !== 0) begin
            $display("FAIL two_extra_starts: got %0d expected 0", starts);
        end else passed++;
    endtask

    task automatic test_overrun();
        int n, starts;
        n = 1 + HDR;
        @(negedge clk); b8.i_result = 8'h01; b8.i_valid = 1'b1;
        @(negedge clk); b8.i_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            total++; if ({b8.o_tx_start, b8.o_tx_data} !== {1'b1, exp_byte(16'h0001, k)}) begin
                $display("FAIL ovr_start[%0d]: start,data got %b,%h expected 1,%h",
                         k, b8.o_tx_start, b8.o_tx_data, exp_byte(16'h0001, k));
            end else passed++;
            @(negedge clk);
            if (k == 0) begin
                b8.i_result = 8'h02; b8.i_valid = 1'b1;
                @(negedge clk); b8.i_valid = 1'b0;
                total++; if (b8.o_overrun !== 1'b1) begin
                    $display("FAIL ovr_flag: got %b expected 1", b8.o_overrun);
                end else passed++;
            end
            b8.i_tx_done = 1'b1;
            @(negedge clk); b8.i_tx_done = 1'b0;
        end
        count_starts(1'b0, 8, starts);
        total++; if (starts !== 0) begin
            $display("FAIL ovr_dropped_starts: got %0d expected 0", starts);
        end else passed++;
        total++; if ({b8.o_overrun, b8.o_busy, b8.o_tx_data} !== {2'b10, 8'h01}) begin
            $display("FAIL ovr_sticky: ovr,busy,data got %b%b,%h expected 10,01",
                     b8.o_overrun, b8.o_busy, b8.o_tx_data);
        end else passed++;
    endtask

    // A strobe landing on the same edge as the last i_tx_done is still dropped.
    task automatic test_overrun_on_last_done();
        int n, starts;
        n = 2 + HDR;
        @(negedge clk); b16.i_result = 16'h5678; b16.i_valid = 1'b1;
        @(negedge clk); b16.i_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            total++; if ({b16.o_tx_start, b16.o_tx_data} !== {1'b1, exp_byte(16'h5678, k)}) begin
                $display("FAIL lastdone_start[%0d]: start,data got %b,%h expected 1,%h",
                         k, b16.o_tx_start, b16.o_tx_data, exp_byte(16'h5678, k));
            end else passed++;
            @(negedge clk);
            b16.i_tx_done = 1'b1;
            if (k == n - 1) begin
                b16.i_result = 16'h9ABC; b16.i_valid = 1'b1;
            end
            @(negedge clk); b16.i_tx_done = 1'b0; b16.i_valid = 1'b0;
        end
        total++; if ({b16.o_overrun, b16.o_busy} !== 2'b10) begin
            $display("FAIL lastdone_flag: ovr,busy got %b%b expected 10", b16.o_overrun, b16.o_busy);
        end else passed++;
        count_starts(1'b1, 6, starts);
        total++; if (starts !== 0) begin
            $display("FAIL lastdone_starts: got %0d expected 0", starts);
        end else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int n, starts;
        n = 2 + HDR;
        @(negedge clk); b16.i_result = 16'hABCD; b16.i_valid = 1'b1;
        @(negedge clk); b16.i_valid = 1'b0;
        total++; if (b16.o_tx_start !== 1'b1) begin
            $display("FAIL midrst_first_start: got %b expected 1", b16.o_tx_start);
        end else passed++;
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        total++; if ({b16.o_tx_start, b16.o_busy, b16.o_overrun, b16.o_tx_data} !== 11'h0) begin
            $display("FAIL midrst_outputs: start,busy,ovr,data got %b%b%b %h expected 000 00",
                     b16.o_tx_start, b16.o_busy, b16.o_overrun, b16.o_tx_data);
        end else passed++;
        total++; if (b8.o_overrun !== 1'b0) begin
            $display("FAIL midrst_ovr_clear: got %b expected 0", b8.o_overrun);
        end else passed++;
        @(negedge clk); b16.i_tx_done = 1'b1;
        @(negedge clk); b16.i_tx_done = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); b16.i_tx_done = 1'b1;
        @(negedge clk); b16.i_tx_done = 1'b0;
        count_starts(1'b1, 8, starts);
        total++; if ({starts, b16.o_busy} !== {32'd0, 1'b0}) begin
            $display("FAIL midrst_no_resume: starts,busy got %0d,%b expected 0,0", starts, b16.o_busy);
        end else passed++;
        @(negedge clk); b16.i_result = 16'hBEEF; b16.i_valid = 1'b1;
        @(negedge clk); b16.i_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            total++; if ({b16.o_tx_start, b16.o_tx_data} !== {1'b1, exp_byte(16'hBEEF, k)}) begin
                $display("FAIL midrst_new_start[%0d]: start,data got %b,%h expected 1,%h",
                         k, b16.o_tx_start, b16.o_tx_data, exp_byte(16'hBEEF, k));
            end else passed++;
            repeat (2) @(negedge clk);
            b16.i_tx_done = 1'b1;
            @(negedge clk); b16.i_tx_done = 1'b0;
        end
        total++; if (b16.o_busy !== 1'b0) begin
            $display("FAIL midrst_new_end: busy got %b expected 0", b16.o_busy);
        end else passed++;
    endtask

    initial begin
        b8.i_result  = '0; b8.i_valid  = 1'b0; b8.i_tx_done  = 1'b0;
        b16.i_result = '0; b16.i_valid = 1'b0; b16.i_tx_done = 1'b0;
        test_reset();
        test_spurious_done();
        test_single_byte();
        test_two_byte();
        test_overrun();
        test_overrun_on_last_done();
        test_reset_mid_frame();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
